// File: rtl/pipeline_stage.sv
// Valid/ready pipeline register. It has two modes: a single register with combinational in_ready,
// or a two-entry skid buffer whose in_ready comes straight from a flop.
module pipeline_stage #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       SKID      = 1,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit              USE_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_rdy;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer_out;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    assign w_in_ready = USE_SKID ? r_rdy : (!r_main_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_xfer_out = r_main_valid && out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_data_nxt  = FLUSH_VAL;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = FLUSH_VAL;
        end else if (USE_SKID) begin
            // A full skid forces in_ready low, so no accept can coincide with the skid drain.
            if (w_xfer_out) begin
                if (r_skid_valid) begin
                    w_main_data_nxt  = r_skid_data;
                    w_skid_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    w_main_data_nxt  = in_data;
                end else begin
                    w_main_valid_nxt = 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid) begin
                    w_main_valid_nxt = 1'b1;
                    w_main_data_nxt  = in_data;
                end else begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = in_data;
                end
            end
        end else begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end else if (w_xfer_out) begin
                w_main_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_main_valid <= 1'b0;
            r_main_data  <= FLUSH_VAL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= FLUSH_VAL;
            r_rdy        <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_rdy        <= !w_skid_valid_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipeline_stage.md
PIPELINE_STAGE -- requirements
Module: pipeline_stage

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload carried through the stage (e.g. 32-bit instruction plus 32-bit next PC).
REQ-002 Parameter SKID, default 1, selects mode: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter FLUSH_VAL, default all-zeros (DATA_W bits), payload value loaded on reset and on flush.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 Port CLK, input, 1, sole clock; all state updates on the rising edge.
REQ-006 Port RST, input, 1, asynchronous active-high reset.
REQ-007 Port flush, input, 1, synchronous squash of all held entries.
REQ-008 Port in_valid, input, 1, upstream presents a payload.
REQ-009 Port in_data, input, DATA_W, upstream payload.
REQ-010 Port in_ready, output, 1, stage accepts a payload this cycle.
REQ-011 Port out_valid, output, 1, stage presents a payload downstream.
REQ-012 Port out_data, output, DATA_W, downstream payload.
REQ-013 Port out_ready, input, 1, downstream accepts this cycle.
REQ-014 Port stall_cnt, output, CNT_W, saturating count of back-pressured cycles.

Function
REQ-015 A transfer in occurs on a cycle with in_valid && in_ready; a transfer out on a cycle with out_valid && out_ready.
REQ-016 out_data and out_valid come directly from the main register; no combinational path exists from in_data to out_data.
REQ-017 SKID=0: in_ready = !out_valid || out_ready; an accepted payload loads the main register; a transfer out with no accept clears out_valid.
REQ-018 SKID=1: in_ready = !skid_valid, driven from a flop only; no combinational path exists from out_ready to in_ready.
REQ-019 SKID=1, accept when main is empty or a transfer out occurs, and skid is empty: payload loads main.
REQ-020 SKID=1, accept while main is held (out_valid && !out_ready): payload loads skid; skid_valid sets; in_ready drops next cycle.
REQ-021 SKID=1, transfer out with skid full: skid moves to main; skid_valid clears; in_ready rises next cycle.
REQ-022 SKID=1: a simultaneous transfer out and accept with skid empty loads main with the new payload, so sustained throughput is 1 per cycle.
REQ-023 No payload is dropped, duplicated or reordered except by flush; ordering is FIFO with depth 1 (SKID=0) or 2 (SKID=1).
REQ-024 Data registers load only when their entry is written; otherwise they hold their value, and no X is introduced.
REQ-025 flush has priority over every other event: next cycle out_valid=0, skid_valid=0, and main and skid data=FLUSH_VAL.
REQ-026 A payload offered during a flush cycle is discarded, even if in_ready was 1.
REQ-027 in_ready=1 on the cycle after a flush in both modes.
REQ-028 stall_cnt increments by 1 each cycle with out_valid && !out_ready && !flush, saturates at 2^CNT_W-1, and never wraps.
REQ-029 flush does not clear stall_cnt.

Reset
REQ-030 While RST=1, asynchronously: out_valid=0, skid_valid=0, main and skid data=FLUSH_VAL, stall_cnt=0.
REQ-031 While RST=1, in_ready=0 in SKID=1 mode, and in_ready=1 in SKID=0 mode because it is combinational.
REQ-032 In SKID=1 mode, in_ready=1 from the first rising edge after RST deasserts.
REQ-033 RST asserted mid-transfer discards all held payloads; no partial state survives.

Verification
REQ-034 Streaming: SKID=1, out_ready=1, in_valid=1 with in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuous, in_ready never low.
REQ-035 Back-pressure: SKID=1, accept 0xA then 0xB while out_ready=0 -> out_data=0xA held, in_ready=0 one cycle after the 0xB accept, stall_cnt counts up.
REQ-036 Back-pressure release: from REQ-035, raise out_ready for 2 cycles -> 0xA then 0xB delivered in order, then out_valid=0 and in_ready=1.
REQ-037 Flush: skid full (0xA, 0xB), flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=FLUSH_VAL, in_ready=1, and 0xC never appears.
REQ-038 Saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
REQ-039 Mode 0 and reset: SKID=0, hold out_ready=0 with out_valid=1, then assert RST asynchronously mid-cycle -> out_valid=0 and stall_cnt=0 immediately, before the next CLK edge.
